// File: rtl/toggle_rx_pkg.sv
// Shared constants for toggle-event receivers.
// TOGGLE_RX_DEGLITCH_EN adds one cycle to the minimum sender spacing.
package toggle_rx_pkg;

    localparam int TOGGLE_SYNC_STAGES = 2;
    localparam int TOGGLE_CNT_W       = 8;

`ifdef TOGGLE_RX_DEGLITCH_EN
    localparam int TOGGLE_MIN_SPACING = TOGGLE_SYNC_STAGES + 3;
`else
    localparam int TOGGLE_MIN_SPACING = TOGGLE_SYNC_STAGES + 2;
`endif

endpackage

// File: rtl/sync_chain.sv
// Parameterized N-flop level synchronizer with asynchronous active-low reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Receive end of the toggle-event protocol: sync, edge decode, event handshake, overrun, count.
// Optional TOGGLE_RX_DEGLITCH_EN adds a stage that rejects one-cycle glitches on the synced level.
module toggle_event_receiver
    import toggle_rx_pkg::*;
#(
    parameter int SYNC_STAGES = TOGGLE_SYNC_STAGES,
    parameter int CNT_W       = TOGGLE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] evt_count,
    output logic             tog_level
);

    logic sync_q;
    logic cand_level;
    logic acc_level;
    logic evt_edge;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tog_in),
        .q     (sync_q)
    );

`ifdef TOGGLE_RX_DEGLITCH_EN
    logic deg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deg_q <= 1'b0;
        end else begin
            deg_q <= sync_q;
        end
    end

    // Accept only a level that has been stable for two consecutive samples.
    assign cand_level = deg_q;
    assign evt_edge   = (sync_q == deg_q) && (deg_q != acc_level);
`else
    assign cand_level = sync_q;
    assign evt_edge   = sync_q ^ acc_level;
`endif

    // Handshake: evt_valid rises with each event and holds until a cycle with
    // evt_valid && evt_ready; a new event on the accept edge keeps it high, a new
    // event while valid and not ready sets overrun. evt_ready with valid low is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_level <= 1'b0;
            evt_pulse <= 1'b0;
            evt_valid <= 1'b0;
            overrun   <= 1'b0;
            evt_count <= '0;
        end else begin
            evt_pulse <= evt_edge;
            if (evt_edge) begin
                acc_level <= cand_level;
            end

            if (evt_edge) begin
                evt_valid <= 1'b1;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (evt_edge && evt_valid && !evt_ready) begin
                overrun <= 1'b1;
            end else if (clr) begin
                overrun <= 1'b0;
            end

            // A clear coinciding with an event keeps that event in the count.
            if (clr) begin
                evt_count <= evt_edge ? CNT_W'(1) : '0;
            end else if (evt_edge) begin
                evt_count <= evt_count + CNT_W'(1);
            end
        end
    end

    assign tog_level = acc_level;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver (SYNC_STAGES=2, CNT_W=4).
module tb_toggle_event_receiver;

`ifdef TOGGLE_RX_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int SPACE = 6;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tog_in = 1'b0;
    logic          clr = 1'b0;
    logic          evt_ready = 1'b0;
    logic          evt_pulse;
    logic          evt_valid;
    logic          overrun;
    logic [CW-1:0] evt_count;
    logic          tog_level;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_cnt;

    toggle_event_receiver #(.SYNC_STAGES(2), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .overrun   (overrun),
        .evt_count (evt_count),
        .tog_level (tog_level)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flip tog_in and advance to the cycle where the decoded pulse is visible.
    task automatic send_event();
        tog_in = ~tog_in;
        step(LAT);
    endtask

    initial begin
        // Reset
        #12;
        chk("rst_pulse", 32'(evt_pulse), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_count", 32'(evt_count), 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_level", 32'(tog_level), 0);

        // First 0->1 event, no consumer
        tog_in = 1'b1;
        step(LAT - 1);
        chk("t1_pulse_early", 32'(evt_pulse), 0);
        step(1);
        chk("t1_pulse", 32'(evt_pulse), 1);
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_count", 32'(evt_count), 1);
        chk("t1_level", 32'(tog_level), 1);
        step(1);
        chk("t1_pulse_one_cycle", 32'(evt_pulse), 0);
        chk("t1_valid_held", 32'(evt_valid), 1);
        step(SPACE - LAT - 1);

        // Accept, then 1->0 event
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("t2_accept", 32'(evt_valid), 0);
        send_event();
        chk("t2_pulse", 32'(evt_pulse), 1);
        chk("t2_valid", 32'(evt_valid), 1);
        chk("t2_count", 32'(evt_count), 2);
        chk("t2_overrun", 32'(overrun), 0);
        chk("t2_level", 32'(tog_level), 0);
        step(SPACE - LAT);

        // Two events 6 cycles apart without accept -> overrun
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        send_event();
        chk("t3_count_a", 32'(evt_count), 3);
        chk("t3_overrun_a", 32'(overrun), 0);
        step(SPACE - LAT);
        send_event();
        chk("t3_count_b", 32'(evt_count), 4);
        chk("t3_overrun_b", 32'(overrun), 1);
        step(5);
        chk("t3_overrun_sticky", 32'(overrun), 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("t3_clr_overrun", 32'(overrun), 0);
        chk("t3_clr_count", 32'(evt_count), 0);
        chk("t3_valid_kept", 32'(evt_valid), 1);

        // 17 events with consumer always ready: count wraps 15->0, ends at 1
        evt_ready = 1'b1;
        exp_cnt = '0;
        for (int k = 0; k < 17; k++) begin
            send_event();
            exp_cnt = exp_cnt + 1'b1;
            chk($sformatf("t4_count_%0d", k), 32'(evt_count), 32'(exp_cnt));
            step(SPACE - LAT);
        end
        chk("t4_final_count", 32'(evt_count), 1);
        chk("t4_overrun", 32'(overrun), 0);
        chk("t4_valid", 32'(evt_valid), 0);
        chk("t4_level", 32'(tog_level), 1);

        // Build count 5 with an overrun, then clr on the pulse edge
        evt_ready = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            send_event();
            chk($sformatf("t5_count_%0d", k), 32'(evt_count), 32'(k));
            step(SPACE - LAT);
        end
        chk("t5_overrun_set", 32'(overrun), 1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        tog_in = ~tog_in;
        step(LAT - 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("t5_pulse", 32'(evt_pulse), 1);
        chk("t5_count", 32'(evt_count), 1);
        chk("t5_overrun", 32'(overrun), 0);
        chk("t5_valid", 32'(evt_valid), 1);
        step(SPACE - LAT);

        // Event while pending -> overrun, then asynchronous reset mid-stream
        send_event();
        chk("t6_overrun", 32'(overrun), 1);
        chk("t6_valid", 32'(evt_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 0);
        chk("t6_rst_overrun", 32'(overrun), 0);
        chk("t6_rst_count", 32'(evt_count), 0);
        chk("t6_rst_pulse", 32'(evt_pulse), 0);
        chk("t6_rst_level", 32'(tog_level), 0);
        tog_in = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("t6_post_count", 32'(evt_count), 0);
        chk("t6_post_valid", 32'(evt_valid), 0);

`ifdef TOGGLE_RX_DEGLITCH_EN
        // One-cycle glitch on tog_in reaches the last sync stage for one cycle only
        tog_in = 1'b1;
        step(1);
        tog_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk($sformatf("t7_no_pulse_%0d", k), 32'(evt_pulse), 0);
        end
        chk("t7_count", 32'(evt_count), 0);
        chk("t7_level", 32'(tog_level), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_event_receiver.md
Name: toggle_event_receiver

Overview:
Receive end of the toggle-event protocol. The sender flips a level, tog_in, once per event, from an unrelated clock or an I/O pin. This block synchronizes the level into clk, decodes each level change into a one-cycle pulse, holds a valid/ready event flag, flags overruns and counts events. It sits behind a dedicated input pin and feeds downstream control logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on tog_in (legal range 2..4)
CNT_W, 8, width of the wrapping event counter (legal range 1..16)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
tog_in  input  1  asynchronous toggle level; one transition = one event
clr  input  1  synchronous clear of evt_count and overrun
evt_ready  input  1  consumer accepts the pending event
evt_pulse  output  1  one-cycle pulse per decoded transition
evt_valid  output  1  event pending, held until accepted
overrun  output  1  sticky: an event arrived while one was still pending
evt_count  output  CNT_W  number of events modulo 2^CNT_W
tog_level  output  1  synchronized, accepted level of tog_in

Behaviour:
- Reset (asynchronous, rst_n low):
  - sync chain, accepted level, evt_pulse, evt_valid, overrun and evt_count all go to 0.
  - tog_level is 0, so the sender must idle tog_in at 0 out of reset.
- Synchronizer: tog_in passes through SYNC_STAGES flops clocked by clk. No other logic is placed in this path.
- Decode:
  - edge = last sync stage XOR accepted level.
  - On each rising clk edge: evt_pulse <= edge, and accepted level <= last sync stage.
  - evt_pulse is always a registered output.
- Latency: a new tog_in level first sampled at rising edge N produces evt_pulse high during the cycle after edge N+SYNC_STAGES. With SYNC_STAGES=2, the pulse follows edge N+2, i.e. the 3rd edge.
- Both rising and falling transitions of tog_in count as events.
- evt_valid:
  - Set on the same edge that sets evt_pulse.
  - Cleared on an edge where evt_valid=1 and evt_ready=1.
  - New event on the same edge as an accept: evt_valid stays 1 and overrun is not set.
  - New event while evt_valid=1 and evt_ready=0: evt_valid stays 1 and overrun is set.
  - evt_ready while evt_valid=0 is ignored.
- overrun: sticky; cleared only by clr or reset. If clr and a new overrun condition occur on the same edge, overrun ends at 1.
- evt_count:
  - Increments by 1 per event and wraps from 2^CNT_W-1 to 0.
  - clr alone: count becomes 0.
  - clr and an event on the same edge: count becomes 1, so no event is lost.
- Sender rule: minimum spacing between tog_in transitions is SYNC_STAGES+2 clk cycles. Faster toggling may merge transitions; this is not detected.
- Reset mid-operation: all state is lost immediately. After reset the sender must return tog_in to 0 before the next event.

Optional Feature:
TOGGLE_RX_DEGLITCH_EN
- Defined:
  - An extra flop follows the sync chain.
  - A transition is accepted only when the last two stages agree and differ from the accepted level.
  - A single-cycle glitch on the synchronized level is rejected.
  - Latency grows by 1 cycle; minimum sender spacing becomes SYNC_STAGES+3.
- Undefined: behaviour exactly as above with no extra flop.

Decomposition:
- Package toggle_rx_pkg holds:
  - default constants TOGGLE_SYNC_STAGES=2 and TOGGLE_CNT_W=8;
  - localparam for the minimum sender spacing.
- One sub-module, sync_chain, is natural: a parameterized N-flop synchronizer with async active-low reset, reusable by other receivers.
- Edge decode, handshake, overrun and counter stay in the top block.

Test Plan:
- Reset, then one 0->1 transition on tog_in, SYNC_STAGES=2, evt_ready=0 -> evt_pulse high for exactly one cycle after the 3rd edge; evt_valid=1 and held; evt_count=1; tog_level=1.
- Raise evt_ready for one cycle, then transition 1->0 -> evt_valid drops to 0, then rises again with the new pulse; evt_count=2; overrun=0.
- Two transitions spaced 6 cycles apart, evt_ready held 0 -> overrun=1 after the second pulse; evt_count=2; overrun stays 1 until clr.
- CNT_W=4, 17 properly spaced transitions -> evt_count sequence wraps 15->0 and ends at 1.
- clr asserted on the edge where a pulse is registered, starting from count 5 -> evt_count=1, overrun=0, evt_valid=1.
- With TOGGLE_RX_DEGLITCH_EN defined: 1-cycle high glitch on the last sync stage -> no pulse and count unchanged. A genuine transition -> pulse after the 4th edge.
- Reset asserted mid-stream with evt_valid=1 and overrun=1 -> all outputs read 0 immediately, before the next clock edge.
